// File: rtl/canny_bit_morph_3x3_pkg.sv
// Shared types and constants for the binary 3x3 morphology stage.
package canny_morph_pkg;

    typedef enum logic {
        MORPH_DILATE = 1'b0,
        MORPH_ERODE  = 1'b1
    } morph_mode_e;

    // Cycles from an input pixel to its morphology result at the output.
    localparam int MORPH_LAT = 2;

endpackage

// File: rtl/canny_bit_morph_3x3_if.sv
// 1-bit video stream: frame/line syncs, pixel qualifier and the edge bit.
interface canny_bit_morph_3x3_if;
    logic frame_vsync;
    logic frame_href;
    logic frame_clken;
    logic img_bit;

    modport master (output frame_vsync, frame_href, frame_clken, img_bit);
    modport slave  (input  frame_vsync, frame_href, frame_clken, img_bit);
endinterface

// File: rtl/canny_bit_morph_3x3_line_buffer.sv
// One-line 1-bit delay line; advances only on qualified pixels, contents never reset.
module bit_line_buffer #(
    parameter int DEPTH = 640
) (
    input  logic clk,
    input  logic clken,
    input  logic din,
    output logic dout
);
    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    // Shift the new pixel in at the bottom; the oldest pixel leaves at the top.
    always_comb begin
        sr_d = {sr_q[DEPTH-2:0], din};
    end

    // Storage is pure data: row masking downstream hides stale contents.
    always_ff @(posedge clk) begin
        if (clken) sr_q <= sr_d;
    end

    assign dout = sr_q[DEPTH-1];
endmodule

// File: rtl/canny_bit_morph_3x3.sv
// Binary 3x3 dilate/erode on a 1-bit edge stream, with per-frame set-pixel count.
module canny_bit_morph_3x3
    import canny_morph_pkg::*;
#(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int CNT_W     = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     morph_mode,
    canny_bit_morph_3x3_if.slave     per_if,
    canny_bit_morph_3x3_if.master    post_if,
    output logic [CNT_W-1:0]         post_edge_count,
    output logic                     post_count_valid
);
    localparam int COL_W = $clog2(IMG_HDISP + 1);
    localparam int ROW_W = $clog2(IMG_VDISP);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    morph_mode_e      mode_q, mode_d;
    logic             vs_low_seen_q, vs_low_seen_d;
    logic             frame_ok_q, frame_ok_d;
    logic [2:0]       sync_q [MORPH_LAT];
    logic [2:0]       sync_d [MORPH_LAT];
    logic [2:0]       w0_q, w1_q, w2_q, w0_d, w1_d, w2_d;
    logic             bit_q, bit_d;
    logic [CNT_W-1:0] acc_q, acc_d, count_q, count_d;
    logic             valid_q, valid_d;
    logic             lb1_out, lb2_out;
    logic             vs_rise, href_fall, out_fall;
    logic [CNT_W-1:0] acc_inc;

    bit_line_buffer #(.DEPTH(IMG_HDISP)) u_lb1 (
        .clk(clk), .clken(per_if.frame_clken), .din(per_if.img_bit), .dout(lb1_out)
    );
    bit_line_buffer #(.DEPTH(IMG_HDISP)) u_lb2 (
        .clk(clk), .clken(per_if.frame_clken), .din(lb1_out), .dout(lb2_out)
    );

    // A frame start only counts once vsync has been seen low since reset, so a
    // reset released mid-frame never looks like a fresh frame.
    assign vs_rise   = per_if.frame_vsync & vs_low_seen_q & ~sync_q[0][2];
    assign href_fall = ~per_if.frame_href & sync_q[0][1];
    assign out_fall  = sync_q[MORPH_LAT-1][2] & ~sync_q[MORPH_LAT-2][2];

    // Sync delay line: {vsync, href, clken} re-timed by MORPH_LAT cycles.
    always_comb begin
        sync_d[0] = {per_if.frame_vsync, per_if.frame_href, per_if.frame_clken};
        for (int k = 1; k < MORPH_LAT; k++) sync_d[k] = sync_q[k-1];
    end

    // Frame/line position tracking and per-frame mode latch.
    always_comb begin
        col_d         = col_q;
        row_d         = row_q;
        mode_d        = mode_q;
        vs_low_seen_d = vs_low_seen_q | ~per_if.frame_vsync;
        if (!per_if.frame_href)      col_d = '0;
        else if (per_if.frame_clken) col_d = col_q + 1'b1;
        if (vs_rise) begin
            row_d  = '0;
            mode_d = morph_mode_e'(morph_mode);
        end else if (href_fall && row_q != ROW_W'(IMG_VDISP - 1)) begin
            row_d = row_q + 1'b1;
        end
    end

    // Stage 0 -> 1: shift a masked column into the 3x3 window (bit i = column x-i).
    always_comb begin
        w0_d = w0_q;
        w1_d = w1_q;
        w2_d = w2_q;
        if (per_if.frame_clken) begin
            w0_d = {(col_q > COL_W'(1)) & w0_q[1], (col_q != '0) & w0_q[0], per_if.img_bit};
            w1_d = {(col_q > COL_W'(1)) & w1_q[1], (col_q != '0) & w1_q[0],
                    lb1_out & (row_q != '0)};
            w2_d = {(col_q > COL_W'(1)) & w2_q[1], (col_q != '0) & w2_q[0],
                    lb2_out & (row_q > ROW_W'(1))};
        end
    end

    // Stage 1 -> 2: reduce the window, forced to 0 off valid pixels.
    always_comb begin
        if (mode_q == MORPH_ERODE) bit_d = sync_q[0][0] & (&{w0_q, w1_q, w2_q});
        else                       bit_d = sync_q[0][0] & (|{w0_q, w1_q, w2_q});
    end

    // Output-side edge count, published on the output vsync fall of complete frames.
    always_comb begin
        acc_inc    = acc_q;
        if (sync_q[MORPH_LAT-1][0] && bit_q && acc_q != '1) acc_inc = acc_q + 1'b1;
        acc_d      = acc_inc;
        count_d    = count_q;
        valid_d    = 1'b0;
        frame_ok_d = frame_ok_q;
        if (out_fall) begin
            acc_d      = '0;
            valid_d    = frame_ok_q;
            frame_ok_d = 1'b0;
            if (frame_ok_q) count_d = acc_inc;
        end
        if (vs_rise) frame_ok_d = 1'b1;
    end

    // All state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q         <= '0;
            row_q         <= '0;
            mode_q        <= MORPH_DILATE;
            vs_low_seen_q <= 1'b0;
            frame_ok_q    <= 1'b0;
            for (int k = 0; k < MORPH_LAT; k++) sync_q[k] <= '0;
            w0_q          <= '0;
            w1_q          <= '0;
            w2_q          <= '0;
            bit_q         <= 1'b0;
            acc_q         <= '0;
            count_q       <= '0;
            valid_q       <= 1'b0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            mode_q        <= mode_d;
            vs_low_seen_q <= vs_low_seen_d;
            frame_ok_q    <= frame_ok_d;
            for (int k = 0; k < MORPH_LAT; k++) sync_q[k] <= sync_d[k];
            w0_q          <= w0_d;
            w1_q          <= w1_d;
            w2_q          <= w2_d;
            bit_q         <= bit_d;
            acc_q         <= acc_d;
            count_q       <= count_d;
            valid_q       <= valid_d;
        end
    end

    assign post_if.frame_vsync = sync_q[MORPH_LAT-1][2];
    assign post_if.frame_href  = sync_q[MORPH_LAT-1][1];
    assign post_if.frame_clken = sync_q[MORPH_LAT-1][0];
    assign post_if.img_bit     = bit_q;
    assign post_edge_count     = count_q;
    assign post_count_valid    = valid_q;
endmodule
